// File: rtl/varint_encoder_p.sv
// varint_encoder_p: protobuf base-128 varint encoder, one output byte per cycle.
// Optional zigzag mapping of signed values is enabled by defining VARINT_ZIGZAG_EN.
module varint_encoder_p #(
    parameter  int DATA_W = 32,
    localparam int MAX_B  = (DATA_W + 6) / 7,
    localparam int LEN_W  = $clog2(MAX_B + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_fifo_empty,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_signed,
    output logic              in_fifo_pop,
    output logic              in_index_pop,
    input  logic              out_fifo_full,
    output logic              out_fifo_clr,
    output logic              out_fifo_push,
    output logic [7:0]        out_data,
    output logic              out_index_clr,
    output logic              out_index_push,
    output logic [LEN_W-1:0]  out_len,
    output logic              busy
);
    typedef enum logic [1:0] {INIT, READY, ENCODE} state_t;

    state_t             state;
    logic [DATA_W-1:0]  sr;
    logic [LEN_W-1:0]   cnt;
    logic [DATA_W-1:0]  enc;
    logic               more;
    logic               fire;
    logic               last;

`ifdef VARINT_ZIGZAG_EN
    assign enc = in_signed ? (in_data << 1) ^ {DATA_W{in_data[DATA_W-1]}} : in_data;
`else
    logic unused_signed;
    assign enc = in_data;
    assign unused_signed = in_signed;
`endif

    // Byte emission and pop decisions; a pop on the last byte chains the next value with no bubble
    always_comb begin
        more           = |sr[DATA_W-1:7];
        fire           = (state == ENCODE) && !out_fifo_full;
        last           = fire && !more;
        out_fifo_push  = fire;
        out_data       = fire ? {more, sr[6:0]} : 8'h00;
        out_index_push = last;
        out_len        = last ? cnt + 1'b1 : '0;
        in_fifo_pop    = !in_fifo_empty && ((state == READY) || last);
        in_index_pop   = in_fifo_pop;
        busy           = (state == ENCODE);
    end

    // State, shift register and byte count; one clear pulse on leaving INIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= INIT;
            sr            <= '0;
            cnt           <= '0;
            out_fifo_clr  <= 1'b0;
            out_index_clr <= 1'b0;
        end else begin
            out_fifo_clr  <= (state == INIT);
            out_index_clr <= (state == INIT);
            case (state)
                INIT:    state <= READY;
                READY:   state <= READY;
                ENCODE:  if (fire) begin
                             sr  <= sr >> 7;
                             cnt <= cnt + 1'b1;
                             if (!more) state <= READY;
                         end
                default: state <= INIT;
            endcase
            if (in_fifo_pop) begin
                sr    <= enc;
                cnt   <= '0;
                state <= ENCODE;
            end
        end
    end
endmodule

// File: tb/tb_varint_encoder_p.sv
// tb_varint_encoder_p: directed checks of varint_encoder_p at DATA_W=32 and DATA_W=64.
module tb_varint_encoder_p;
    logic        clk = 1'b0;
    logic        reset;
    logic        e32, s32, full32, pop32, ipop32, fclr32, push32, iclr32, ipush32, busy32;
    logic [31:0] d32;
    logic [7:0]  od32;
    logic [2:0]  len32;
    logic        e64, s64, full64, pop64, ipop64, fclr64, push64, iclr64, ipush64, busy64;
    logic [63:0] d64;
    logic [7:0]  od64;
    logic [3:0]  len64;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    varint_encoder_p #(.DATA_W(32)) u32 (
        .clk(clk), .reset(reset), .in_fifo_empty(e32), .in_data(d32), .in_signed(s32),
        .in_fifo_pop(pop32), .in_index_pop(ipop32), .out_fifo_full(full32),
        .out_fifo_clr(fclr32), .out_fifo_push(push32), .out_data(od32),
        .out_index_clr(iclr32), .out_index_push(ipush32), .out_len(len32), .busy(busy32)
    );

    varint_encoder_p #(.DATA_W(64)) u64 (
        .clk(clk), .reset(reset), .in_fifo_empty(e64), .in_data(d64), .in_signed(s64),
        .in_fifo_pop(pop64), .in_index_pop(ipop64), .out_fifo_full(full64),
        .out_fifo_clr(fclr64), .out_fifo_push(push64), .out_data(od64),
        .out_index_clr(iclr64), .out_index_push(ipush64), .out_len(len64), .busy(busy64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 with the 32-bit encoder in READY
    task automatic send32(input string tag, input logic [31:0] v, input logic s,
                          input logic [7:0] b [10], input int n);
        d32 = v;
        s32 = s;
        e32 = 1'b0;
        @(negedge clk);
        chk({tag, "_pop"}, {pop32, ipop32}, 2'b11);
        chk({tag, "_nopush_at_pop"}, push32, 1'b0);
        cyc;
        e32 = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_b%0d", tag, i), {push32, od32}, {1'b1, b[i]});
            chk($sformatf("%s_ip%0d", tag, i), ipush32, (i == n - 1));
            if (i == n - 1) chk({tag, "_len"}, len32, n);
            chk($sformatf("%s_nopop%0d", tag, i), pop32, 1'b0);
            cyc;
        end
        @(negedge clk);
        chk({tag, "_idle"}, {push32, ipush32, busy32}, 3'b000);
        cyc;
    endtask

    initial begin
        reset = 1'b0;
        e32 = 1'b1; s32 = 1'b0; full32 = 1'b0; d32 = '0;
        e64 = 1'b1; s64 = 1'b0; full64 = 1'b0; d64 = '0;
        @(negedge clk);
        chk("rst_strobes", {pop32, push32, ipush32, fclr32, iclr32, busy32}, 6'b0);
        chk("rst_data", {od32, len32}, 11'b0);
        cyc;
        reset = 1'b1;
        cyc;
        @(negedge clk);
        chk("init_clr", {fclr32, iclr32, fclr64, iclr64}, 4'b1111);
        cyc;
        @(negedge clk);
        chk("init_clr_off", {fclr32, iclr32}, 2'b00);
        chk("ready_idle", {busy32, pop32, push32}, 3'b000);
        cyc;

        send32("basic", 32'hAEB48F8A, 1'b0, '{0:8'h8A, 1:8'h9F, 2:8'hD2, 3:8'hF5, 4:8'h0A, default:8'h00}, 5);

        // Stall on a full output FIFO while the input value changes underneath
        d32 = 32'h81;
        e32 = 1'b0;
        @(negedge clk);
        chk("stall_pop", pop32, 1'b1);
        cyc;
        e32 = 1'b1;
        @(negedge clk);
        chk("stall_b0", {push32, od32, ipush32}, {1'b1, 8'h81, 1'b0});
        cyc;
        full32 = 1'b1;
        d32 = 32'h12345678;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("stall_hold%0d", i), {push32, ipush32, busy32}, 3'b001);
            cyc;
        end
        full32 = 1'b0;
        @(negedge clk);
        chk("stall_b1", {push32, od32, ipush32, len32}, {1'b1, 8'h01, 1'b1, 3'd2});
        cyc;
        @(negedge clk);
        chk("stall_idle", {push32, busy32}, 2'b00);
        cyc;

        // Back-to-back single-byte values
        d32 = 32'h0;
        e32 = 1'b0;
        @(negedge clk);
        chk("b2b_pop0", pop32, 1'b1);
        cyc;
        d32 = 32'h7F;
        @(negedge clk);
        chk("b2b_b0", {push32, od32, ipush32, len32}, {1'b1, 8'h00, 1'b1, 3'd1});
        chk("b2b_pop1", {pop32, ipop32}, 2'b11);
        cyc;
        e32 = 1'b1;
        @(negedge clk);
        chk("b2b_b1", {push32, od32, ipush32, len32}, {1'b1, 8'h7F, 1'b1, 3'd1});
        chk("b2b_nopop", pop32, 1'b0);
        cyc;
        @(negedge clk);
        chk("b2b_idle", {push32, busy32}, 2'b00);
        cyc;

`ifdef VARINT_ZIGZAG_EN
        send32("zz_m1", 32'hFFFFFFFF, 1'b1, '{0:8'h01, default:8'h00}, 1);
        send32("zz_p1", 32'h00000001, 1'b1, '{0:8'h02, default:8'h00}, 1);
        send32("zz_min", 32'h80000000, 1'b1, '{0:8'hFF, 1:8'hFF, 2:8'hFF, 3:8'hFF, 4:8'h0F, default:8'h00}, 5);
`else
        send32("nz_p1", 32'h00000001, 1'b1, '{0:8'h01, default:8'h00}, 1);
        send32("nz_min", 32'h80000000, 1'b1, '{0:8'h80, 1:8'h80, 2:8'h80, 3:8'h80, 4:8'h08, default:8'h00}, 5);
`endif
        send32("uns_m1", 32'hFFFFFFFF, 1'b0, '{0:8'hFF, 1:8'hFF, 2:8'hFF, 3:8'hFF, 4:8'h0F, default:8'h00}, 5);

        // Full-width 64-bit value
        d64 = 64'hFFFFFFFFFFFFFFFF;
        e64 = 1'b0;
        @(negedge clk);
        chk("w64_pop", pop64, 1'b1);
        cyc;
        e64 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("w64_b%0d", i), {push64, od64, ipush64}, {1'b1, (i == 9) ? 8'h01 : 8'hFF, i == 9});
            cyc;
        end
        chk("w64_len_prev", 64'(u64.out_len), 64'd0);
        @(negedge clk);
        chk("w64_idle", {push64, busy64}, 2'b00);
        cyc;

        // Reset in the middle of an encode
        d32 = 32'hAEB48F8A;
        e32 = 1'b0;
        cyc;
        e32 = 1'b1;
        @(negedge clk);
        chk("mid_b0", {push32, od32}, {1'b1, 8'h8A});
        cyc;
        @(negedge clk);
        chk("mid_b1", {push32, od32}, {1'b1, 8'h9F});
        cyc;
        reset = 1'b0;
        #1;
        chk("mid_rst", {push32, ipush32, busy32, pop32, od32}, 12'b0);
        cyc;
        reset = 1'b1;
        cyc;
        @(negedge clk);
        chk("mid_clr", {fclr32, iclr32, push32, ipush32}, 4'b1100);
        cyc;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mid_quiet%0d", i), {fclr32, iclr32, push32, ipush32, busy32}, 5'b0);
            cyc;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
